// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the memory stage.
//   word_t          32-bit data/address word
//   regbits_t       register index
//   memctl_state_t  memory-stage controller FSM states
//   RESV_W          width of a word-granular reservation address (addr[31:2])
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    localparam int RESV_W = 30;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } memctl_state_t;

    // Word index of a byte address; reservations compare at word granularity.
    function automatic logic [RESV_W-1:0] word_idx(input word_t a);
        return a[31:2];
    endfunction

endpackage

// File: rtl/mem_resv_unit.sv
// LR/SC reservation register (one word, one valid bit).
// Ports:
//   CLK, nRST      clock, async active-low reset
//   set, set_addr  LR completed: reserve the word at set_addr
//   clr            SC issued or own store hit the reserved word
//   chk_addr       address to test against the reservation
//   snoop_inv      coherence invalidate this cycle, at snoop_addr
//   chk_hit        reservation valid, matches chk_addr, and not killed by
//                  a coincident matching invalidate
module mem_resv_unit
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  set,
    input  word_t set_addr,
    input  logic  clr,
    input  word_t chk_addr,
    input  logic  snoop_inv,
    input  word_t snoop_addr,
    output logic  chk_hit
);

    logic              resv_valid_q, resv_valid_d;
    logic [RESV_W-1:0] resv_addr_q,  resv_addr_d;
    logic              snoop_hit;
    logic              unused_lsb;

    assign snoop_hit  = resv_valid_q & snoop_inv & (word_idx(snoop_addr) == resv_addr_q);
    // A same-cycle invalidate beats the SC check.
    assign chk_hit    = resv_valid_q & (word_idx(chk_addr) == resv_addr_q) & ~snoop_hit;
    assign unused_lsb = ^{set_addr[1:0], chk_addr[1:0], snoop_addr[1:0]};

    always_comb begin
        resv_valid_d = resv_valid_q;
        resv_addr_d  = resv_addr_q;
        if (set) begin
            // An invalidate to the word being reserved lands after the LR.
            resv_valid_d = ~(snoop_inv & (word_idx(snoop_addr) == word_idx(set_addr)));
            resv_addr_d  = word_idx(set_addr);
        end else if (clr | snoop_hit) begin
            resv_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            resv_valid_q <= 1'b0;
            resv_addr_q  <= '0;
        end else begin
            resv_valid_q <= resv_valid_d;
            resv_addr_q  <= resv_addr_d;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage access controller between EX/MEM and MEM/WB.
// Holds a registered dcache request until dhit, stalls the pipe meanwhile,
// and captures load data (or SC status) for MEM/WB.
// Optional feature macro: MEM_STAGE_ATOMIC_EN (LR/SC reservation).
// Ports:
//   CLK, nRST                     clock, async active-low reset
//   req_ren/req_wen/req_lr/req_sc EX/MEM op and atomic qualifiers
//   req_addr, req_wdata           effective address and store data
//   advance                       EX/MEM -> MEM/WB transfer this cycle
//   dhit, dmemload                dcache completion and read data
//   ccinv, ccsnoopaddr            coherence invalidate snoop
//   dmemREN/WEN/addr/store        registered dcache request
//   mem_stall                     stall to hazard unit (combinational)
//   mem_rdata                     load data or SC status for MEM/WB
//   mem_timeout                   sticky watchdog error
module mem_stage_ctrl
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 11
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  req_ren,
    input  logic  req_wen,
    input  logic  req_lr,
    input  logic  req_sc,
    input  word_t req_addr,
    input  word_t req_wdata,
    input  logic  advance,
    input  logic  dhit,
    input  word_t dmemload,
    input  logic  ccinv,
    input  word_t ccsnoopaddr,
    output logic  dmemREN,
    output logic  dmemWEN,
    output word_t dmemaddr,
    output word_t dmemstore,
    output logic  mem_stall,
    output word_t mem_rdata,
    output logic  mem_timeout
);

    memctl_state_t    state_q, state_d;
    logic             ren_q, ren_d, wen_q, wen_d;
    word_t            addr_q, addr_d, store_q, store_d, rdata_q, rdata_d;
    logic             is_load_q, is_load_d, is_sc_q, is_sc_d, is_lr_q, is_lr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             tmo_q, tmo_d;
    logic             op, sc_req, lr_req, sc_fail;

    assign op = req_ren | req_wen;

`ifdef MEM_STAGE_ATOMIC_EN
    logic resv_hit, resv_set, resv_clr;

    assign sc_req   = req_wen & ~req_ren & req_sc;
    assign lr_req   = req_ren & req_lr;
    assign sc_fail  = sc_req & ~resv_hit;
    assign resv_set = (state_q == BUSY) & dhit & is_lr_q;
    // Any SC drops the reservation; so does an own plain store to that word.
    assign resv_clr = (state_q == IDLE) & req_wen & ~req_ren & (req_sc | resv_hit);

    mem_resv_unit u_resv (
        .CLK        (CLK),
        .nRST       (nRST),
        .set        (resv_set),
        .set_addr   (addr_q),
        .clr        (resv_clr),
        .chk_addr   (req_addr),
        .snoop_inv  (ccinv),
        .snoop_addr (ccsnoopaddr),
        .chk_hit    (resv_hit)
    );
`else
    logic unused_atomic;

    assign sc_req        = 1'b0;
    assign lr_req        = 1'b0;
    assign sc_fail       = 1'b0;
    assign unused_atomic = ^{req_lr, req_sc, ccinv, ccsnoopaddr, is_lr_q};
`endif

    // Watchdog counter saturates at TIMEOUT_CYC.
    assign cnt_inc = (cnt_q == CNT_W'(TIMEOUT_CYC)) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        ren_d     = ren_q;
        wen_d     = wen_q;
        addr_d    = addr_q;
        store_d   = store_q;
        rdata_d   = rdata_q;
        is_load_d = is_load_q;
        is_sc_d   = is_sc_q;
        is_lr_d   = is_lr_q;
        cnt_d     = '0;
        tmo_d     = tmo_q;
        case (state_q)
            IDLE: begin
                if (op) begin
                    if (sc_fail) begin
                        rdata_d = 32'd1;
                        state_d = DONE;
                    end else begin
                        // Both enables set is illegal; the read wins.
                        ren_d     = req_ren;
                        wen_d     = ~req_ren;
                        addr_d    = req_addr;
                        store_d   = req_wdata;
                        is_load_d = req_ren;
                        is_sc_d   = sc_req;
                        is_lr_d   = lr_req;
                        state_d   = BUSY;
                    end
                end
            end
            BUSY: begin
                if (TIMEOUT_CYC != 0) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(TIMEOUT_CYC)) tmo_d = 1'b1;
                end
                if (dhit) begin
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = DONE;
                    if (is_load_q)    rdata_d = dmemload;
                    else if (is_sc_q) rdata_d = 32'd0;
                end
            end
            DONE: begin
                if (advance) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            ren_q     <= 1'b0;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            store_q   <= '0;
            rdata_q   <= '0;
            is_load_q <= 1'b0;
            is_sc_q   <= 1'b0;
            is_lr_q   <= 1'b0;
            cnt_q     <= '0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ren_q     <= ren_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            store_q   <= store_d;
            rdata_q   <= rdata_d;
            is_load_q <= is_load_d;
            is_sc_q   <= is_sc_d;
            is_lr_q   <= is_lr_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    assign mem_stall   = ((state_q == IDLE) & op) | (state_q == BUSY);
    assign dmemREN     = ren_q;
    assign dmemWEN     = wen_q;
    assign dmemaddr    = addr_q;
    assign dmemstore   = store_q;
    assign mem_rdata   = rdata_q;
    assign mem_timeout = tmo_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0, nRST = 1'b0;
    logic  req_ren = 0, req_wen = 0, req_lr = 0, req_sc = 0;
    word_t req_addr = '0, req_wdata = '0;
    logic  advance = 0, dhit = 0, ccinv = 0;
    word_t dmemload = '0, ccsnoopaddr = '0;
    logic  dmemREN, dmemWEN, mem_stall, mem_timeout;
    word_t dmemaddr, dmemstore, mem_rdata;

    int    n_chk = 0, n_fail = 0;
    word_t sb_q[$];
    word_t mdl;
    int    tmo_at;

    mem_stage_ctrl #(.TIMEOUT_CYC(8), .CNT_W(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_ren(req_ren), .req_wen(req_wen), .req_lr(req_lr), .req_sc(req_sc),
        .req_addr(req_addr), .req_wdata(req_wdata), .advance(advance),
        .dhit(dhit), .dmemload(dmemload), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .mem_stall(mem_stall), .mem_rdata(mem_rdata), .mem_timeout(mem_timeout)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one access, answer with dhit after dly request cycles, check the
    // request shape and stall count, pop the expected result in DONE, hold DONE
    // for 'hold' cycles, then advance and check the return to idle.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic lr, input logic sc, input word_t a, input word_t wd,
                          input int dly, input word_t ld, input word_t exp_rd,
                          input logic exp_req, input logic inv, input int hold,
                          output int tmo_first);
        int    stall_n = 0, ren_n = 0, wen_n = 0, req_n = 0, cyc = 0, bad = 0;
        logic  done = 1'b0;
        word_t exp;
        tmo_first = -1;
        sb_q.push_back(exp_rd);
        @(negedge CLK);
        req_ren = rd; req_wen = wr; req_lr = lr; req_sc = sc;
        req_addr = a; req_wdata = wd; advance = 1'b0;
        ccinv = inv; ccsnoopaddr = a;
        while (!done && cyc < 64) begin
            #1;
            if (mem_stall) stall_n++;
            if (dmemREN) ren_n++;
            if (dmemWEN) wen_n++;
            if (dmemREN | dmemWEN) begin
                req_n++;
                if (req_n == 1) begin
                    chk({tag, "_addr"}, dmemaddr, a);
                    if (wr && !rd) chk({tag, "_store"}, dmemstore, wd);
                end
            end
            if (mem_timeout && tmo_first < 0) tmo_first = req_n;
            if (cyc > 0 && !mem_stall) done = 1'b1;
            else begin
                dhit     = (dmemREN | dmemWEN) && (req_n == dly);
                dmemload = dhit ? ld : word_t'($urandom);
                @(negedge CLK);
                cyc++;
                ccinv = 1'b0;
            end
        end
        dhit = 1'b0;
        chk({tag, "_completed"}, 32'(done), 32'd1);
        chk({tag, "_stall_n"}, stall_n, exp_req ? dly + 1 : 1);
        chk({tag, "_ren_n"}, ren_n, (exp_req && rd) ? dly : 0);
        chk({tag, "_wen_n"}, wen_n, (exp_req && wr && !rd) ? dly : 0);
        if (sb_q.size() == 0) chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        else begin
            exp = sb_q.pop_front();
            chk({tag, "_rdata"}, mem_rdata, exp);
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge CLK); #1;
            if (mem_stall || dmemREN || dmemWEN || mem_rdata !== exp_rd) bad++;
        end
        if (hold > 0) chk({tag, "_hold_bad"}, bad, 0);
        advance = 1'b1;
        @(posedge CLK); #1;
        advance = 1'b0; req_ren = 0; req_wen = 0; req_lr = 0; req_sc = 0;
        @(negedge CLK); #1;
        chk({tag, "_idle_stall"}, 32'(mem_stall | dmemREN | dmemWEN), 32'd0);
        chk({tag, "_idle_rdata"}, mem_rdata, exp_rd);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_ren", 32'(dmemREN), 0);
        chk("rst_wen", 32'(dmemWEN), 0);
        chk("rst_addr", dmemaddr, 0);
        chk("rst_store", dmemstore, 0);
        chk("rst_stall", 32'(mem_stall), 0);
        chk("rst_rdata", mem_rdata, 0);
        chk("rst_tmo", 32'(mem_timeout), 0);
        @(negedge CLK); nRST = 1'b1;

        // Load with dhit on the third request cycle
        access("ld100", 1, 0, 0, 0, 32'h100, 0, 3, 32'hDEADBEEF, 32'hDEADBEEF, 1, 0, 0, tmo_at);
        mdl = 32'hDEADBEEF;
        // Store held in DONE: one write burst, no reissue, rdata unchanged
        access("st104", 0, 1, 0, 0, 32'h104, 32'h55, 2, 32'h0, mdl, 1, 0, 5, tmo_at);

        // Reset while BUSY
        @(negedge CLK);
        req_ren = 1; req_addr = 32'h180;
        @(negedge CLK); @(negedge CLK); #1;
        chk("rstbusy_ren_before", 32'(dmemREN), 1);
        nRST = 1'b0; #1;
        chk("rstbusy_ren", 32'(dmemREN), 0);
        chk("rstbusy_rdata", mem_rdata, 0);
        req_ren = 0; #1;
        chk("rstbusy_idle", 32'(mem_stall), 0);
        @(negedge CLK); nRST = 1'b1;
        access("ld_after_rst", 1, 0, 0, 0, 32'h180, 0, 1, 32'hCAFEF00D, 32'hCAFEF00D, 1, 0, 0, tmo_at);
        mdl = 32'hCAFEF00D;

        // Both enables: read wins
        access("rdwr", 1, 1, 0, 0, 32'h1C0, 32'h99, 2, 32'h12345678, 32'h12345678, 1, 0, 0, tmo_at);
        mdl = 32'h12345678;

`ifdef MEM_STAGE_ATOMIC_EN
        access("lr200", 1, 0, 1, 0, 32'h200, 0, 2, 32'h0000_1234, 32'h0000_1234, 1, 0, 0, tmo_at);
        access("sc200", 0, 1, 0, 1, 32'h200, 32'h77, 1, 0, 32'd0, 1, 0, 0, tmo_at);
        access("sc200_2", 0, 1, 0, 1, 32'h200, 32'h78, 1, 0, 32'd1, 0, 0, 0, tmo_at);
        access("lr300", 1, 0, 1, 0, 32'h300, 0, 1, 32'h0000_ABCD, 32'h0000_ABCD, 1, 0, 0, tmo_at);
        access("sc300_inv", 0, 1, 0, 1, 32'h300, 32'h11, 1, 0, 32'd1, 0, 1, 0, tmo_at);
        access("lr400", 1, 0, 1, 0, 32'h400, 0, 1, 32'h0000_4444, 32'h0000_4444, 1, 0, 0, tmo_at);
        access("st400", 0, 1, 0, 0, 32'h400, 32'h22, 1, 0, 32'h0000_4444, 1, 0, 0, tmo_at);
        access("sc400", 0, 1, 0, 1, 32'h400, 32'h33, 1, 0, 32'd1, 0, 0, 0, tmo_at);
        mdl = 32'd1;
`else
        // Qualifiers ignored: LR is a load, SC a plain store
        access("lr200", 1, 0, 1, 0, 32'h200, 0, 2, 32'h0000_1234, 32'h0000_1234, 1, 0, 0, tmo_at);
        access("sc200", 0, 1, 0, 1, 32'h200, 32'h77, 1, 0, 32'h0000_1234, 1, 1, 0, tmo_at);
        access("sc200_2", 0, 1, 0, 1, 32'h200, 32'h78, 1, 0, 32'h0000_1234, 1, 0, 0, tmo_at);
        mdl = 32'h0000_1234;
`endif

        // Watchdog: 8 BUSY cycles without dhit
        chk("tmo_pre", 32'(mem_timeout), 0);
        access("ld_tmo", 1, 0, 0, 0, 32'h500, 0, 12, 32'h0000_600D, 32'h0000_600D, 1, 0, 0, tmo_at);
        chk("tmo_first_seen", tmo_at, 9);
        chk("tmo_sticky", 32'(mem_timeout), 1);
        access("ld_post_tmo", 1, 0, 0, 0, 32'h504, 0, 1, 32'h0000_0ABC, 32'h0000_0ABC, 1, 0, 0, tmo_at);
        chk("tmo_sticky2", 32'(mem_timeout), 1);
        @(negedge CLK); nRST = 1'b0; #1;
        chk("tmo_reset", 32'(mem_timeout), 0);
        @(negedge CLK); nRST = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
